pipe_stage_reg: RTL and testbench

//  Generic replacement for the per-stage pipeline latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic pipeline stage register with valid/ready handshake and optional skid buffer
//
// Holds one (SKID=0) or up to two (SKID=1) DATA_W-bit beats between pipeline
// stages and obeys the hazard unit's mode_i: flush drops everything held, stall
// freezes the stage, any other code runs normally.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous reset, active-high
//   mode_i   in   hazard control (MODE_FLUSH, MODE_STALL, others = run)
//   valid_i  in   upstream beat valid
//   ready_o  out  stage can accept a beat this cycle
//   data_i   in   upstream payload
//   valid_o  out  downstream beat valid (registered)
//   ready_i  in   downstream can accept
//   data_o   out  downstream payload (registered)
//   count_o  out  entries held (0..2 with skid, 0..1 without)

module pipe_stage_reg #(
    parameter int          DATA_W     = 64,
    parameter int          SKID       = 1,
    parameter int          FLUSH_ZERO = 1,
    parameter logic [1:0]  MODE_FLUSH = 2'd1,
    parameter logic [1:0]  MODE_STALL = 2'd2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic              valid_q;
    logic              full_q;
    logic [1:0]        count_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    logic stall;
    logic flush;
    logic acc;
    logic out;

    assign stall = (mode_i == MODE_STALL);
    assign flush = (mode_i == MODE_FLUSH);

    // Only the stall term is combinational in the skid variant; the
    // occupancy term comes straight from a flop so the ready path is cut.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign ready_o = ~full_q & ~stall;
        end else begin : g_flat_ready
            assign ready_o = (~valid_q | ready_i) & ~stall;
        end
    endgenerate

    assign acc = valid_i & ready_o;
    assign out = valid_q & ready_i & ~stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            count_q <= 2'd0;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            // A beat offered during a flush is dropped even if ready_o was high.
            state_q <= EMPTY;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            count_q <= 2'd0;
            if (FLUSH_ZERO != 0) begin
                main_q <= '0;
            end
        end else if (!stall) begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_q  <= data_i;
                        state_q <= BUSY;
                        valid_q <= 1'b1;
                        count_q <= 2'd1;
                    end
                end
                BUSY: begin
                    if (acc && out) begin
                        main_q <= data_i;
                    end else if (acc) begin
                        // Only reachable with the skid buffer: without it,
                        // ready_o is low whenever main is held and not draining.
                        skid_q  <= data_i;
                        state_q <= FULL;
                        full_q  <= 1'b1;
                        count_q <= 2'd2;
                    end else if (out) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                        count_q <= 2'd0;
                    end
                end
                FULL: begin
                    if (out) begin
                        main_q  <= skid_q;
                        state_q <= BUSY;
                        full_q  <= 1'b0;
                        count_q <= 2'd1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    full_q  <= 1'b0;
                    count_q <= 2'd0;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign data_o  = main_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, skid and non-skid variants side by side

module tb_pipe_stage_reg;

    localparam int         W       = 16;
    localparam logic [1:0] M_RUN   = 2'd0;
    localparam logic [1:0] M_FLUSH = 2'd1;
    localparam logic [1:0] M_STALL = 2'd2;
    localparam logic [1:0] M_RSV   = 2'd3;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         valid_i;
    logic         ready_i;
    logic [W-1:0] data_i;

    logic         ready_o [2];
    logic         valid_o [2];
    logic [W-1:0] data_o  [2];
    logic [1:0]   count_o [2];

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int skid, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (skid=%0d) at %0t: got %0h, expected %0h", name, skid, $time, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : gi
            localparam int SK = (g == 0) ? 1 : 0;

            pipe_stage_reg #(
                .DATA_W    (W),
                .SKID      (SK),
                .FLUSH_ZERO(1),
                .MODE_FLUSH(M_FLUSH),
                .MODE_STALL(M_STALL)
            ) dut (
                .clk_i  (clk),
                .rst_i  (rst),
                .mode_i (mode),
                .valid_i(valid_i),
                .ready_o(ready_o[g]),
                .data_i (data_i),
                .valid_o(valid_o[g]),
                .ready_i(ready_i),
                .data_o (data_o[g]),
                .count_o(count_o[g])
            );

            // Reference model: a FIFO of accepted beats with a capacity of 2
            // (skid) or 1 (no skid, but may drain and refill in one cycle).
            logic [W-1:0] sb [$];
            int           occ      = 0;
            bit           zero_exp = 1'b1;

            always @(posedge clk) begin : model
                bit rdy;
                bit acc_m;
                bit out_m;
                if (rst || mode == M_FLUSH) begin
                    sb.delete();
                    occ      <= 0;
                    zero_exp <= 1'b1;
                end else if (mode != M_STALL) begin
                    rdy   = (SK != 0) ? (occ < 2) : (occ == 0 || ready_i);
                    acc_m = valid_i && rdy;
                    out_m = (occ > 0) && ready_i;
                    if (acc_m) begin
                        sb.push_back(data_i);
                        zero_exp <= 1'b0;
                    end
                    occ <= occ + int'(acc_m) - int'(out_m);
                end
            end

            // Monitor: retire the head beat on a transfer, compare whatever
            // the DUT presents between edges.
            always @(posedge clk) begin : mon_pop
                if (chk_en && !rst && mode != M_FLUSH && mode != M_STALL && occ > 0 && ready_i) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", SK, 1, 0);
                    end else begin
                        void'(sb.pop_front());
                    end
                end
            end

            always @(negedge clk) begin : mon_cmp
                bit exp_rdy;
                if (chk_en) begin
                    exp_rdy = (mode != M_STALL) && ((SK != 0) ? (occ < 2) : (occ == 0 || ready_i));
                    chk("count_o", SK, longint'(count_o[g]), longint'(occ));
                    chk("valid_o", SK, longint'(valid_o[g]), longint'(occ > 0));
                    chk("ready_o", SK, longint'(ready_o[g]), longint'(exp_rdy));
                    if (occ > 0 && sb.size() > 0) begin
                        chk("data_o", SK, longint'(data_o[g]), longint'(sb[0]));
                    end else if (occ == 0 && zero_exp) begin
                        chk("data_o_zero", SK, longint'(data_o[g]), 0);
                    end
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input logic [1:0] m);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        mode    = m;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'hAAAA;
        ready_i = 1'b1;
        mode    = M_RUN;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, M_RUN);

        for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, M_RUN);
        drive(1'b0, '0, 1'b1, M_RUN);
        drive(1'b0, '0, 1'b1, M_RUN);

        drive(1'b1, 16'h11, 1'b0, M_RUN);
        drive(1'b1, 16'h22, 1'b0, M_RUN);
        drive(1'b1, 16'h33, 1'b0, M_RUN);
        drive(1'b1, 16'h33, 1'b0, M_RUN);
        drive(1'b1, 16'h33, 1'b1, M_RUN);
        drive(1'b1, 16'h33, 1'b1, M_RUN);
        drive(1'b0, '0, 1'b1, M_RUN);
        drive(1'b0, '0, 1'b1, M_RUN);

        drive(1'b1, 16'h11, 1'b0, M_RUN);
        drive(1'b1, 16'h22, 1'b0, M_RUN);
        repeat (3) drive(1'b0, '0, 1'b1, M_STALL);
        drive(1'b1, 16'h44, 1'b1, M_FLUSH);
        drive(1'b0, '0, 1'b1, M_RUN);
        drive(1'b0, '0, 1'b1, M_RSV);

        for (int i = 0; i < 3000; i++) begin
            int mr;
            mr   = int'($urandom_range(0, 99));
            rst  = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 3) != 0), W'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  (mr < 4) ? M_FLUSH : (mr < 14) ? M_STALL : (mr < 24) ? M_RSV : M_RUN);
        end
        rst = 1'b0;
        repeat (4) drive(1'b0, '0, 1'b1, M_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
